// File: rtl/dds_pkg.sv
// Shared definitions for the multi-waveform DDS.
// Mode codes and scale helpers used by the generator.
package dds_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_SINE   = 2'd0;
   localparam mode_t MODE_SQUARE = 2'd1;
   localparam mode_t MODE_TRI    = 2'd2;
   localparam mode_t MODE_SAW    = 2'd3;

   function automatic longint unsigned dds_mid(input int dw);
      return 64'd1 << (dw - 1);
   endfunction

   function automatic longint unsigned dds_full(input int dw);
      return (64'd1 << dw) - 64'd1;
   endfunction

endpackage

// File: rtl/dds_sine_rom.sv
// Quarter-wave sine magnitude table with a registered read.
// Entries are built at elaboration, centred on half-LSB phase steps.
module dds_sine_rom #(
   parameter int AW = 9,
   parameter int DW = 9
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   output logic [DW-1:0] data
);

   localparam real PI = 3.14159265358979323846;

   function automatic logic [DW-1:0] entry(input int idx);
      real a;
      a = (2.0 ** DW - 1.0) *
          $sin(PI / 2.0 * (real'(idx) + 0.5) / (2.0 ** AW));
      return DW'($rtoi(a + 0.5));
   endfunction

   logic [DW-1:0] tab [2**AW];

   for (genvar g = 0; g < 2**AW; g++) begin : g_tab
      assign tab[g] = entry(g);
   end

   always_ff @(posedge clk) begin
      data <= tab[addr];
   end

endmodule

// File: rtl/dds_wave_gen.sv
// Phase accumulator plus 3-stage waveform pipeline with a
// valid/ready config port and optional wrap-synchronous update.
module dds_wave_gen
   import dds_pkg::*;
#(
   parameter int ACC_W  = 32,
   parameter int ADDR_W = 11,
   parameter int DATA_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [ACC_W-1:0]  cfg_k,
   input  logic [ADDR_W-1:0] cfg_p,
   input  logic [1:0]        cfg_mode,
   input  logic              cfg_sync,
   output logic [DATA_W-1:0] wave_out,
   output logic              out_valid,
   output logic              wrap
);

   localparam int QW = ADDR_W - 2;
   localparam int HW = DATA_W - 1;
   localparam logic [DATA_W-1:0] H = DATA_W'(dds_mid(DATA_W));
   localparam logic [DATA_W-1:0] M = DATA_W'(dds_full(DATA_W));

   logic [ACC_W-1:0]  acc, k, sh_k;
   logic [ADDR_W-1:0] p, sh_p;
   mode_t             mode, sh_mode;
   logic              pending;
   logic [ACC_W:0]    sum;
   logic              take, swap;

   assign sum       = {1'b0, acc} + {1'b0, k};
   assign cfg_ready = !pending;
   assign take      = cfg_valid & cfg_ready;
   // Carry on the acceptance edge is excluded because pending is still low there.
   assign swap      = pending & en & sum[ACC_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         k       <= '0;
         p       <= '0;
         mode    <= MODE_SINE;
         pending <= 1'b0;
         wrap    <= 1'b0;
      end else begin
         wrap <= en & sum[ACC_W];
         if (en) acc <= sum[ACC_W-1:0];
         if (swap) begin
            k       <= sh_k;
            p       <= sh_p;
            mode    <= sh_mode;
            pending <= 1'b0;
         end else if (take && !cfg_sync) begin
            k    <= cfg_k;
            p    <= cfg_p;
            mode <= cfg_mode;
         end else if (take) begin
            pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (take && cfg_sync) begin
         sh_k    <= cfg_k;
         sh_p    <= cfg_p;
         sh_mode <= cfg_mode;
      end
   end

   logic [ADDR_W-1:0] ph;
   logic [ADDR_W-1:0] s1_ph;
   logic [1:0]        s1_q;
   logic [QW-1:0]     s1_idx;
   mode_t             s1_mode;
   logic              s1_v;

   assign ph = acc[ACC_W-1 -: ADDR_W] + p;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_ph   <= '0;
         s1_q    <= '0;
         s1_idx  <= '0;
         s1_mode <= MODE_SINE;
         s1_v    <= 1'b0;
      end else begin
         s1_ph   <= ph;
         s1_q    <= ph[ADDR_W-1:ADDR_W-2];
         s1_idx  <= ph[QW-1:0];
         s1_mode <= mode;
         s1_v    <= en;
      end
   end

   logic [QW-1:0]     rom_a;
   logic [HW-1:0]     rom_d;
   logic [ADDR_W-2:0] tw;
   logic [DATA_W-1:0] lin;

   assign rom_a = s1_idx ^ {QW{s1_q[0]}};
   assign tw    = s1_ph[ADDR_W-2:0] ^ {(ADDR_W-1){s1_ph[ADDR_W-1]}};

   dds_sine_rom #(
      .AW(QW),
      .DW(HW)
   ) u_rom (
      .clk (clk),
      .addr(rom_a),
      .data(rom_d)
   );

   always_comb begin
      lin = '0;
      unique case (1'b1)
         s1_mode == MODE_SQUARE: lin = s1_ph[ADDR_W-1] ? '0 : M;
         s1_mode == MODE_TRI:    lin = tw[ADDR_W-2 -: DATA_W];
         s1_mode == MODE_SAW:    lin = s1_ph[ADDR_W-1 -: DATA_W];
         default:                lin = '0;
      endcase
   end

   logic [DATA_W-1:0] s2_lin;
   mode_t             s2_mode;
   logic              s2_neg;
   logic              s2_v;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_lin  <= '0;
         s2_mode <= MODE_SINE;
         s2_neg  <= 1'b0;
         s2_v    <= 1'b0;
      end else begin
         s2_lin  <= lin;
         s2_mode <= s1_mode;
         s2_neg  <= s1_q[1];
         s2_v    <= s1_v;
      end
   end

   logic [DATA_W-1:0] fold;

   always_comb begin
      fold = s2_lin;
      if (s2_mode == MODE_SINE) begin
         fold = s2_neg ? (H - 1'b1) - {1'b0, rom_d} : H + {1'b0, rom_d};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wave_out  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= s2_v;
         if (s2_v) wave_out <= fold;
      end
   end

endmodule
